// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one ALU among NREQ requesters.
// The result goes out through one registered response channel, tagged with the requester index.
module alu_rr_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int CNTW  = 16,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*4-1:0]     req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_out1,
    output logic [WIDTH-1:0]      rsp_out2,
    output logic [2*WIDTH-1:0]    rsp_out3,
    output logic [CNTW-1:0]       grant_count
);

    localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gnt_id;
    logic [IDW:0]     idx;
    logic             found;
    logic             can_acc;
    logic             do_grant;
    logic [NREQ-1:0]  grant;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] alu_out;

    // Gated by rst so the handshake also reads as zero while reset is held.
    assign can_acc = (!rsp_valid || rsp_ready) && !rst;

    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = {1'b0, ptr} + (IDW+1)'(off);
            if (idx >= NREQ_W) begin
                idx = idx - NREQ_W;
            end
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found  = 1'b1;
                gnt_id = idx[IDW-1:0];
            end
        end
        if (found && can_acc) begin
            grant[gnt_id] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign do_grant  = |grant;

    assign sel_a  = req_a[gnt_id*WIDTH +: WIDTH];
    assign sel_b  = req_b[gnt_id*WIDTH +: WIDTH];
    assign sel_op = req_op[gnt_id*4 +: 4];

    always_comb begin
        alu_out = '0;
        case (sel_op[1:0])
            2'b11:   alu_out = sel_a + sel_b;
            2'b10:   alu_out = sel_a - sel_b;
            2'b01:   alu_out = sel_a & sel_b;
            default: alu_out = sel_a | sel_b;
        endcase
    end

    // out2/out3 are registered rather than derived so they also read 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_out1    <= '0;
            rsp_out2    <= '0;
            rsp_out3    <= '0;
            grant_count <= '0;
        end else begin
            if (do_grant) begin
                rsp_valid <= 1'b1;
                rsp_id    <= gnt_id;
                rsp_out1  <= alu_out;
                rsp_out2  <= ~alu_out;
                rsp_out3  <= {alu_out, ~alu_out};
                ptr       <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
                if (grant_count != {CNTW{1'b1}}) begin
                    grant_count <= grant_count + 1'b1;
                end
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched: a reference model predicts the grants,
// and the expected results are queued and compared when the response appears.
module tb_alu_rr_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [15:0] req_a, req_b, req_op;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_out1, rsp_out2;
    logic [7:0]  rsp_out3;
    logic [15:0] grant_count;

    logic [3:0]  s_ready;
    logic        s_valid;
    logic [1:0]  s_id;
    logic [3:0]  s_out1, s_out2;
    logic [7:0]  s_out3;
    logic [1:0]  s_count;

    logic [3:0] a_in [4];
    logic [3:0] b_in [4];
    logic [3:0] op_in[4];

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] out1;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t last_rsp;
    int   ptr_m;
    logic rv_m;
    int   cnt_m;
    int   checks;
    int   failures;
    int   last_k;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_a[i*4 +: 4]  = a_in[i];
            req_b[i*4 +: 4]  = b_in[i];
            req_op[i*4 +: 4] = op_in[i];
        end
    end

    alu_rr_sched #(.NREQ(4), .WIDTH(4), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out1(rsp_out1), .rsp_out2(rsp_out2), .rsp_out3(rsp_out3),
        .grant_count(grant_count)
    );

    alu_rr_sched #(.NREQ(4), .WIDTH(4), .CNTW(2)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(s_valid), .rsp_ready(rsp_ready), .rsp_id(s_id),
        .rsp_out1(s_out1), .rsp_out2(s_out2), .rsp_out3(s_out3),
        .grant_count(s_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] alu_m(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] op);
        logic [4:0] t;
        case (op[1:0])
            2'd3:    begin t = {1'b0, a} + {1'b0, b};            return t[3:0]; end
            2'd2:    begin t = {1'b0, a} + {1'b0, ~b} + 5'd1;    return t[3:0]; end
            2'd1:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic int pick(input logic [3:0] v, input int p);
        for (int off = 0; off < 4; off++) begin
            if (v[(p + off) % 4]) return (p + off) % 4;
        end
        return -1;
    endfunction

    // Drive phase is already done; check the handshake, clock once, then check the response.
    task automatic step();
        int k;
        logic [3:0] exp_g;
        rsp_t e;
        #1;
        k = (!rv_m || rsp_ready) ? pick(req_valid, ptr_m) : -1;
        exp_g = (k >= 0) ? (4'b0001 << k) : 4'b0000;
        chk("req_ready", {28'd0, req_ready}, {28'd0, exp_g});
        if (k >= 0) begin
            e.id   = 2'(k);
            e.out1 = alu_m(a_in[k], b_in[k], op_in[k]);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        last_k = k;
        if (k >= 0) begin
            ptr_m = (k + 1) % 4;
            rv_m  = 1'b1;
            cnt_m++;
        end else if (rsp_ready) begin
            rv_m = 1'b0;
        end
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, rv_m});
        chk("grant_count", {16'd0, grant_count}, cnt_m);
        if (k >= 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_rsp = e;
        end else begin
            e = last_rsp;
        end
        if (rv_m) begin
            chk("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
            chk("rsp_out1", {28'd0, rsp_out1}, {28'd0, e.out1});
            chk("rsp_out2", {28'd0, rsp_out2}, {28'd0, ~e.out1});
            chk("rsp_out3", {24'd0, rsp_out3}, {24'd0, e.out1, ~e.out1});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 0);
        chk("rst_out1", {28'd0, rsp_out1}, 0);
        chk("rst_out2", {28'd0, rsp_out2}, 0);
        chk("rst_out3", {24'd0, rsp_out3}, 0);
        chk("rst_count", {16'd0, grant_count}, 0);
        chk("rst_req_ready", {28'd0, req_ready}, 0);
        chk("rst_sat_count", {30'd0, s_count}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ptr_m = 0;
        rv_m  = 1'b0;
        cnt_m = 0;
        exp_q.delete();
        last_rsp = '0;
    endtask

    initial begin
        logic [1:0] fair_ids[6];
        logic [1:0] sat_exp[5];
        checks = 0;
        failures = 0;
        fair_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        sat_exp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 4; i++) begin
            a_in[i] = 4'(i + 1); b_in[i] = 4'(i + 2); op_in[i] = 4'(i);
        end
        @(posedge clk);
        #1;
        do_reset();

        // Test 1: fill the response register, then reset it mid-operation.
        req_valid = 4'b1111;
        step();
        chk("t1_rsp_valid_before", {31'd0, rsp_valid}, 1);
        do_reset();
        req_valid = 4'b1111;
        step();
        chk("t1_first_grant", {30'd0, rsp_id}, 0);

        // Test 2: add wrap on requester 1.
        req_valid = 4'b0010;
        a_in[1] = 4'd9; b_in[1] = 4'd8; op_in[1] = 4'b0011;
        step();
        chk("t2_id", {30'd0, rsp_id}, 1);
        chk("t2_out1", {28'd0, rsp_out1}, 32'h1);
        chk("t2_out2", {28'd0, rsp_out2}, 32'hE);
        chk("t2_out3", {24'd0, rsp_out3}, 32'h1E);

        // Test 3: the remaining ops on requester 2; op[3:2] must be ignored.
        req_valid = 4'b0100;
        a_in[2] = 4'd3; b_in[2] = 4'd5;
        op_in[2] = 4'b0010; step(); chk("t3_sub", {28'd0, rsp_out1}, 32'hE);
        op_in[2] = 4'b0001; step(); chk("t3_and", {28'd0, rsp_out1}, 32'h1);
        op_in[2] = 4'b0000; step(); chk("t3_or",  {28'd0, rsp_out1}, 32'h7);
        op_in[2] = 4'b1111; step(); chk("t3_add_hi", {28'd0, rsp_out1}, 32'h8);

        // Test 4: fairness starting from a freshly reset pointer.
        req_valid = 4'b0000;
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t4_rr_id", {30'd0, rsp_id}, {30'd0, fair_ids[i]});
        end
        chk("t4_count6", {16'd0, grant_count}, 6);

        // Test 5: backpressure holds everything, then drain and refill together.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in[1] = 4'(i + 5);
            step();
            chk("t5_hold_id", {30'd0, rsp_id}, 1);
        end
        rsp_ready = 1'b1;
        req_valid = 4'b1000;
        step();
        chk("t5_refill_id", {30'd0, rsp_id}, 3);

        // Test 6: saturating counter on the narrow instance.
        req_valid = 4'b0000;
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_sat_count", {30'd0, s_count}, {30'd0, sat_exp[i]});
        end

        // Randomised traffic against the model.
        for (int n = 0; n < 300; n++) begin
            if (last_k >= 0 || req_valid == 4'b0000) begin
                req_valid = 4'($urandom_range(0, 15));
            end
            for (int i = 0; i < 4; i++) begin
                a_in[i]  = 4'($urandom_range(0, 15));
                b_in[i]  = 4'($urandom_range(0, 15));
                op_in[i] = 4'($urandom_range(0, 15));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
